lexer_stream: RTL and testbench

//  Parametrised streaming lexer, successor to the single-stage whitespace lexer.

---
 rtl/lexer_pkg.sv | 77 +++++++
 rtl/lexer_tok_fifo.sv | 64 ++++++
 rtl/lexer_stream.sv | 205 ++++++++++++++++++++
 tb/tb_lexer_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lexer_pkg.sv
// Token kind codes, byte classification and keyword lookup shared by the
// streaming lexer and its bench-facing consumers.
package lexer_pkg;

   localparam logic [7:0] TK_NONE      = 8'h00;
   localparam logic [7:0] TK_NUM       = 8'h01;
   localparam logic [7:0] TK_IDENT     = 8'h02;
   localparam logic [7:0] TK_EOF       = 8'h03;
   localparam logic [7:0] TK_ERR       = 8'h04;
   localparam logic [7:0] TK_OP_PLUS   = 8'h10;
   localparam logic [7:0] TK_OP_MINUS  = 8'h11;
   localparam logic [7:0] TK_OP_STAR   = 8'h12;
   localparam logic [7:0] TK_OP_SLASH  = 8'h13;
   localparam logic [7:0] TK_OP_LPAREN = 8'h14;
   localparam logic [7:0] TK_OP_RPAREN = 8'h15;
   localparam logic [7:0] TK_OP_SEMI   = 8'h16;
   localparam logic [7:0] TK_OP_ASSIGN = 8'h17;
   localparam logic [7:0] TK_OP_LT     = 8'h18;
   localparam logic [7:0] TK_OP_GT     = 8'h19;
   localparam logic [7:0] TK_KW_IF     = 8'h20;
   localparam logic [7:0] TK_KW_ELSE   = 8'h21;
   localparam logic [7:0] TK_KW_WHILE  = 8'h22;
   localparam logic [7:0] TK_KW_RETURN = 8'h23;
   localparam logic [7:0] TK_KW_INT    = 8'h24;

   // Longest keyword; only this many leading word chars are kept for lookup.
   localparam int unsigned KW_MAX_LEN = 6;

   typedef enum logic [2:0] {
      CL_DELIM, CL_EOF, CL_DIGIT, CL_LETTER, CL_OP, CL_OTHER
   } byte_class_e;

   typedef enum logic [1:0] {S_IDLE, S_NUM, S_WORD, S_DONE} lex_state_e;

   function automatic logic [7:0] op_kind(input logic [7:0] b);
      case (b)
         8'h2B:   return TK_OP_PLUS;
         8'h2D:   return TK_OP_MINUS;
         8'h2A:   return TK_OP_STAR;
         8'h2F:   return TK_OP_SLASH;
         8'h28:   return TK_OP_LPAREN;
         8'h29:   return TK_OP_RPAREN;
         8'h3B:   return TK_OP_SEMI;
         8'h3D:   return TK_OP_ASSIGN;
         8'h3C:   return TK_OP_LT;
         8'h3E:   return TK_OP_GT;
         default: return TK_NONE;
      endcase
   endfunction

   function automatic byte_class_e classify(input logic [7:0] b);
      if (b == 8'h09 || b == 8'h0A || b == 8'h0D || b == 8'h20) return CL_DELIM;
      if (b == 8'h00 || b == 8'hFF) return CL_EOF;
      if (b >= 8'h30 && b <= 8'h39) return CL_DIGIT;
      if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A) || b == 8'h5F)
         return CL_LETTER;
      if (op_kind(b) != TK_NONE) return CL_OP;
      return CL_OTHER;
   endfunction

   // t[0] is the first character of the word.
   function automatic logic [7:0] kw_kind(input logic [KW_MAX_LEN-1:0][7:0] t,
                                          input int unsigned len);
      logic [7:0] k;
      k = TK_NONE;
      case (len)
         2: if ({t[0], t[1]} == "if") k = TK_KW_IF;
         3: if ({t[0], t[1], t[2]} == "int") k = TK_KW_INT;
         4: if ({t[0], t[1], t[2], t[3]} == "else") k = TK_KW_ELSE;
         5: if ({t[0], t[1], t[2], t[3], t[4]} == "while") k = TK_KW_WHILE;
         6: if ({t[0], t[1], t[2], t[3], t[4], t[5]} == "return") k = TK_KW_RETURN;
         default: k = TK_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/lexer_tok_fifo.sv
// Token FIFO accepting up to two in-order writes and one pop per cycle;
// reports next-cycle free slots so the producer can throttle ahead of time.
module lexer_tok_fifo #(
   parameter int unsigned W     = 24,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       wr0_en,
   input  logic [W-1:0]               wr0_data,
   input  logic                       wr1_en,
   input  logic [W-1:0]               wr1_data,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH):0]     free_nxt
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wp;
   logic [CW-1:0] count_q, count_d;
   logic          pop;

   always_comb begin
      mem_d = mem_q;
      wp    = wr_ptr_q;
      pop   = rd_en && (count_q != '0);
      if (wr0_en) begin
         mem_d[wp] = wr0_data;
         wp        = wp + 1'b1;
      end
      if (wr1_en) begin
         mem_d[wp] = wr1_data;
         wp        = wp + 1'b1;
      end
      wr_ptr_d = wp;
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
      free_nxt = CW'(DEPTH) - count_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/lexer_stream.sv
// Streaming lexer: classifies source bytes, accumulates numbers/words and
// pushes {kind,value} tokens into a 2-write token FIFO.
module lexer_stream
   import lexer_pkg::*;
#(
   parameter int unsigned MAX_TOK_LEN = 8,
   parameter int unsigned NUM_W       = 16,
   parameter int unsigned KIND_W      = 8,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_VALID,
   output logic              I_READY,
   input  logic [7:0]        I_DATA,
   output logic              O_VALID,
   input  logic              O_READY,
   output logic [KIND_W-1:0] O_KIND,
   output logic [NUM_W-1:0]  O_VALUE,
   output logic              FOUND_EOF,
   output logic              ERROR
);
   localparam int unsigned TOK_W = KIND_W + NUM_W;
   localparam int unsigned LEN_W = $clog2(MAX_TOK_LEN + 2);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   lex_state_e                  state_q, state_d;
   logic [NUM_W-1:0]            acc_q, acc_d;
   logic                        ovf_q, ovf_d, bad_q, bad_d;
   logic [LEN_W-1:0]            len_q, len_d, len_inc;
   logic [7:0]                  hash_q, hash_d;
   logic [KW_MAX_LEN-1:0][7:0]  kw_buf_q, kw_buf_d;
   logic                        found_eof_q, found_eof_d, error_q, error_d;
   logic                        i_ready_q, i_ready_d;

   logic                        accept, too_long;
   byte_class_e                 cls;
   logic [NUM_W+3:0]            acc_wide;
   logic [7:0]                  kw;
   logic [TOK_W-1:0]            num_tok, word_tok, term_tok;
   logic                        wr0_en, wr1_en;
   logic [TOK_W-1:0]            wr0_data, wr1_data, rd_data;
   logic [CNT_W-1:0]            free_nxt;

   function automatic logic [TOK_W-1:0] mk_tok(input logic [7:0] k, input logic [NUM_W-1:0] v);
      return {KIND_W'(k), v};
   endfunction

   always_comb begin
      accept   = I_VALID && i_ready_q;
      cls      = classify(I_DATA);
      acc_wide = (NUM_W+4)'(acc_q) * (NUM_W+4)'(10) + (NUM_W+4)'(I_DATA[3:0]);
      // Length saturates one past the limit so it can never wrap back under.
      too_long = (len_q > LEN_W'(MAX_TOK_LEN));
      len_inc  = too_long ? len_q : len_q + 1'b1;
      kw       = kw_kind(kw_buf_q, 32'(len_q));

      if (bad_q || too_long) num_tok = mk_tok(TK_ERR, '0);
      else if (ovf_q)        num_tok = mk_tok(TK_ERR, '1);
      else                   num_tok = mk_tok(TK_NUM, acc_q);

      if (too_long)          word_tok = mk_tok(TK_ERR, '0);
      else if (kw != TK_NONE) word_tok = mk_tok(kw, '0);
      else                   word_tok = mk_tok(TK_IDENT, NUM_W'(hash_q));

      case (cls)
         CL_OP:   term_tok = mk_tok(op_kind(I_DATA), '0);
         CL_EOF:  term_tok = mk_tok(TK_EOF, '0);
         default: term_tok = mk_tok(TK_ERR, NUM_W'(I_DATA));
      endcase

      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      bad_d       = bad_q;
      len_d       = len_q;
      hash_d      = hash_q;
      kw_buf_d    = kw_buf_q;
      found_eof_d = found_eof_q;
      wr0_en      = 1'b0;
      wr1_en      = 1'b0;
      wr0_data    = term_tok;
      wr1_data    = term_tok;

      if (accept) begin
         case (state_q)
            S_IDLE: begin
               case (cls)
                  CL_DIGIT: begin
                     state_d = S_NUM;
                     acc_d   = NUM_W'(I_DATA[3:0]);
                     ovf_d   = 1'b0;
                     bad_d   = 1'b0;
                     len_d   = LEN_W'(1);
                  end
                  CL_LETTER: begin
                     state_d     = S_WORD;
                     hash_d      = I_DATA;
                     len_d       = LEN_W'(1);
                     kw_buf_d    = '0;
                     kw_buf_d[0] = I_DATA;
                  end
                  CL_DELIM: ;
                  default: wr0_en = 1'b1;
               endcase
            end
            S_NUM: begin
               case (cls)
                  CL_DIGIT: begin
                     acc_d = acc_wide[NUM_W-1:0];
                     ovf_d = ovf_q || (acc_wide[NUM_W+3:NUM_W] != '0);
                     len_d = len_inc;
                  end
                  CL_LETTER: begin
                     bad_d = 1'b1;
                     len_d = len_inc;
                  end
                  default: begin
                     wr0_en   = 1'b1;
                     wr0_data = num_tok;
                     wr1_en   = (cls != CL_DELIM);
                     state_d  = S_IDLE;
                  end
               endcase
            end
            S_WORD: begin
               case (cls)
                  CL_DIGIT, CL_LETTER: begin
                     hash_d = hash_q ^ I_DATA;
                     len_d  = len_inc;
                     for (int unsigned i = 0; i < KW_MAX_LEN; i++)
                        if (32'(len_q) == i) kw_buf_d[i] = I_DATA;
                  end
                  default: begin
                     wr0_en   = 1'b1;
                     wr0_data = word_tok;
                     wr1_en   = (cls != CL_DELIM);
                     state_d  = S_IDLE;
                  end
               endcase
            end
            default: ;
         endcase
         if (cls == CL_EOF) begin
            state_d     = S_DONE;
            found_eof_d = 1'b1;
         end
      end

      error_d = error_q
              | (wr0_en && (wr0_data[TOK_W-1 -: KIND_W] == KIND_W'(TK_ERR)))
              | (wr1_en && (wr1_data[TOK_W-1 -: KIND_W] == KIND_W'(TK_ERR)));
      // Two free slots cover the worst case of a token plus its terminator.
      i_ready_d = (state_d != S_DONE) && (free_nxt >= CNT_W'(2));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
         len_q       <= '0;
         hash_q      <= '0;
         kw_buf_q    <= '0;
         found_eof_q <= 1'b0;
         error_q     <= 1'b0;
         i_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         bad_q       <= bad_d;
         len_q       <= len_d;
         hash_q      <= hash_d;
         kw_buf_q    <= kw_buf_d;
         found_eof_q <= found_eof_d;
         error_q     <= error_d;
         i_ready_q   <= i_ready_d;
      end
   end

   lexer_tok_fifo #(
      .W     (TOK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .wr0_en   (wr0_en),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_data (wr1_data),
      .rd_en    (O_READY),
      .rd_valid (O_VALID),
      .rd_data  (rd_data),
      .free_nxt (free_nxt)
   );

   assign O_KIND    = rd_data[TOK_W-1 -: KIND_W];
   assign O_VALUE   = rd_data[NUM_W-1:0];
   assign I_READY   = i_ready_q;
   assign FOUND_EOF = found_eof_q;
   assign ERROR     = error_q;

endmodule

// File: tb/tb_lexer_stream.sv
// Scoreboard bench for lexer_stream: expected tokens are queued as source
// text is driven and checked in order as the FIFO head is popped.
module tb_lexer_stream;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        I_VALID = 1'b0;
   logic        I_READY;
   logic [7:0]  I_DATA = '0;
   logic        O_VALID;
   logic        O_READY = 1'b1;
   logic [7:0]  O_KIND;
   logic [15:0] O_VALUE;
   logic        FOUND_EOF;
   logic        ERROR;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [23:0] exp_q[$];

   always #5 CLK = ~CLK;

   lexer_stream #(
      .MAX_TOK_LEN (8),
      .NUM_W       (16),
      .KIND_W      (8),
      .FIFO_DEPTH  (4)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .I_VALID   (I_VALID),
      .I_READY   (I_READY),
      .I_DATA    (I_DATA),
      .O_VALID   (O_VALID),
      .O_READY   (O_READY),
      .O_KIND    (O_KIND),
      .O_VALUE   (O_VALUE),
      .FOUND_EOF (FOUND_EOF),
      .ERROR     (ERROR)
   );

   function automatic logic [7:0] xhash(input string s);
      logic [7:0] h = '0;
      for (int i = 0; i < s.len(); i++) h = h ^ s[i];
      return h;
   endfunction

   task automatic push(input logic [7:0] k, input logic [15:0] v);
      exp_q.push_back({k, v});
   endtask

   // Called at a negedge; I_READY is registered so it holds until the next posedge.
   task automatic send_b(input logic [7:0] b);
      int t = 0;
      while (!I_READY && t < 300) begin
         @(negedge CLK);
         t++;
      end
      if (!I_READY) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: I_READY=%b after %0d cycles, required 1", I_READY, t);
         return;
      end
      I_VALID = 1'b1;
      I_DATA  = b;
      @(negedge CLK);
      I_VALID = 1'b0;
   endtask

   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++) send_b(s[i]);
      send_b(8'h00);
   endtask

   task automatic drain(input int budget);
      logic [23:0] e;
      int t = 0;
      while (exp_q.size() > 0 && t < budget) begin
         if (O_VALID && O_READY) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({O_KIND, O_VALUE} !== e) begin
               n_err++;
               $display("FAIL token: got kind=%h value=%h, required kind=%h value=%h",
                        O_KIND, O_VALUE, e[23:16], e[15:0]);
            end
         end
         @(negedge CLK);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d tokens still expected, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset;
      RST     = 1'b1;
      I_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic check_idle_after(input string name, input logic eof_req, input logic err_req);
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({O_VALID, FOUND_EOF, ERROR, I_READY} !== {1'b0, eof_req, err_req, ~eof_req}) begin
         n_err++;
         $display("FAIL %s_end: O_VALID/FOUND_EOF/ERROR/I_READY=%b%b%b%b, required %b%b%b%b",
                  name, O_VALID, FOUND_EOF, ERROR, I_READY, 1'b0, eof_req, err_req, ~eof_req);
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      O_READY = 1'b1;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({O_VALID, O_KIND, O_VALUE, FOUND_EOF, ERROR, I_READY} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {O_VALID, O_KIND, O_VALUE, FOUND_EOF, ERROR, I_READY});
      end
      RST = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (I_READY !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: I_READY=%b, required 1", I_READY);
      end
   endtask

   task automatic test_basic;
      do_reset();
      push(8'h01, 16'd12);
      push(8'h01, 16'd345);
      push(8'h03, 16'd0);
      fork
         feed("12 345");
         drain(400);
      join
      check_idle_after("basic", 1'b1, 1'b0);
   endtask

   task automatic test_ops;
      do_reset();
      push(8'h02, 16'h0061);
      push(8'h10, 16'd0);
      push(8'h02, 16'h0062);
      push(8'h16, 16'd0);
      push(8'h03, 16'd0);
      fork
         feed("a+b;");
         drain(400);
      join
      check_idle_after("ops", 1'b1, 1'b0);
   endtask

   task automatic test_keywords;
      do_reset();
      push(8'h22, 16'd0);
      push(8'h02, {8'h00, 8'h78 ^ 8'h39});
      push(8'h04, 16'hFFFF);
      push(8'h04, 16'd0);
      push(8'h03, 16'd0);
      fork
         feed("while x9 99999 abcdefghi");
         drain(400);
      join
      check_idle_after("keywords", 1'b1, 1'b1);
   endtask

   task automatic test_boundaries;
      do_reset();
      push(8'h01, 16'hFFFF);
      push(8'h04, 16'hFFFF);
      push(8'h02, {8'h00, xhash("abcdefgh")});
      push(8'h04, 16'd0);
      push(8'h20, 16'd0);
      push(8'h24, 16'd0);
      push(8'h21, 16'd0);
      push(8'h23, 16'd0);
      push(8'h03, 16'd0);
      fork
         feed("65535 65536 abcdefgh 12a if int else return");
         drain(600);
      join
      check_idle_after("boundaries", 1'b1, 1'b1);
   endtask

   task automatic test_backpressure;
      do_reset();
      O_READY = 1'b0;
      for (int i = 1; i <= 5; i++) push(8'h01, 16'(i));
      push(8'h03, 16'd0);
      fork
         feed("1 2 3 4 5");
         begin
            repeat (20) @(negedge CLK);
            n_cmp++;
            if (I_READY !== 1'b0) begin
               n_err++;
               $display("FAIL bp_ready: I_READY=%b, required 0", I_READY);
            end
            n_cmp++;
            if ({O_VALID, O_KIND, O_VALUE} !== {1'b1, 8'h01, 16'd1}) begin
               n_err++;
               $display("FAIL bp_head: got valid=%b kind=%h value=%h, required 1 01 0001",
                        O_VALID, O_KIND, O_VALUE);
            end
            O_READY = 1'b1;
            drain(400);
         end
      join
      check_idle_after("backpressure", 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_token;
      do_reset();
      send_b("a");
      send_b("b");
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({O_VALID, O_KIND, O_VALUE, FOUND_EOF, ERROR, I_READY} !== 28'h0) begin
         n_err++;
         $display("FAIL midreset_outputs: got %h, required 0",
                  {O_VALID, O_KIND, O_VALUE, FOUND_EOF, ERROR, I_READY});
      end
      RST = 1'b0;
      @(negedge CLK);
      push(8'h01, 16'd7);
      push(8'h03, 16'd0);
      fork
         feed("7");
         drain(400);
      join
      check_idle_after("midreset", 1'b1, 1'b0);
   endtask

   task automatic test_err_byte;
      do_reset();
      n_cmp++;
      if (ERROR !== 1'b0) begin
         n_err++;
         $display("FAIL errbyte_pre: ERROR=%b, required 0", ERROR);
      end
      push(8'h04, 16'h0040);
      push(8'h01, 16'd5);
      push(8'h16, 16'd0);
      push(8'h03, 16'd0);
      fork
         feed("@5;");
         drain(400);
      join
      check_idle_after("errbyte", 1'b1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ops();
      test_keywords();
      test_boundaries();
      test_backpressure();
      test_reset_mid_token();
      test_err_byte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
